// File: rtl/demux_pkg.sv
// demux_pkg: constants and types shared by the demux1_4_router block.
//   NUM_CH / SEL_W : channel count and select width
//   DEF_WIDTH      : default data word width
//   DEF_CNT_W      : default delivered-word counter width
//   slot_state_e   : per-channel slot occupancy
//   sel_decode()   : binary channel index to one-hot
package demux_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding slot for a single router channel.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : accept load_data into the slot this cycle
//   load_data  : word to store
//   out_ready  : consumer takes the held word this cycle
//   out_valid  : slot holds a word
//   out_data   : held word (changes only on load)
//   out_count  : number of words delivered, wraps modulo 2^CNT_W
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             deliver;

  always_comb begin
    deliver = (state_q == SLOT_FULL) && out_ready;
    state_d = state_q;
    // A load wins over a delivery in the same cycle: the slot refills
    // without a bubble.
    if (load) begin
      state_d = SLOT_FULL;
    end else if (deliver) begin
      state_d = SLOT_EMPTY;
    end
    data_d  = load ? load_data : data_q;
    count_d = count_q + {{(CNT_W-1){1'b0}}, deliver};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule

// File: rtl/demux1_4_router.sv
// demux1_4_router: registered 1-to-4 demultiplexer with per-channel
// one-entry slots and valid/ready handshakes.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : producer presents a word
//   in_ready   : word accepted this cycle (combinational on sel/state/ready)
//   in_sel     : destination channel 0..3
//   in_data    : word to route
//   out_valid  : bit k set when channel k holds a word
//   out_ready  : bit k set when consumer k takes its word
//   out_data   : channel k word in [k*WIDTH +: WIDTH]
//   out_count  : channel k delivered count in [k*CNT_W +: CNT_W]
module demux1_4_router
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] out_count
);

  logic [NUM_CH-1:0] load_en;

  // Only the addressed slot gates acceptance, so a stalled consumer never
  // blocks traffic bound for another channel.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign load_en  = (in_valid && in_ready) ? sel_decode(in_sel) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_en[gi]),
        .load_data (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[gi*WIDTH +: WIDTH]),
        .out_count (out_count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux1_4_router.sv
module tb_demux1_4_router;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [31:0]  in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
  logic [31:0]  out_count;

  demux1_4_router dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: channel occupancy, held word and delivered count.
  bit          m_full [4];
  logic [31:0] m_data [4];
  int          m_cnt  [4];
  bit          seen_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_v;
    for (int k = 0; k < 4; k++) exp_v[k] = m_full[k];
    chk("out_valid", {28'h0, out_valid}, {28'h0, exp_v});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_count[%0d]", k), {24'h0, out_count[k*8 +: 8]}, m_cnt[k]);
      if (m_full[k]) chk($sformatf("out_data[%0d]", k), out_data[k*32 +: 32], m_data[k]);
    end
  endtask

  // Called in the negedge phase; returns in the next negedge phase.
  task automatic cyc(input bit v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    bit acc;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    seen_rdy = in_ready;
    chk("in_ready", {31'h0, in_ready}, {31'h0, (!m_full[s] || r[s])});
    acc = v && (!m_full[s] || r[s]);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (m_full[k] && r[k]) begin
        m_full[k] = 1'b0;
        m_cnt[k]  = (m_cnt[k] + 1) % 256;
      end
    end
    if (acc) begin
      m_full[s] = 1'b1;
      m_data[s] = d;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst out_valid", {28'h0, out_valid}, 32'h0);
    chk("rst out_count", out_count, 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst out_data[%0d]", k), out_data[k*32 +: 32], 32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      chk($sformatf("rst in_ready sel%0d", s), {31'h0, in_ready}, 32'h1);
    end
  endtask

  typedef struct {
    bit          v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  r;
    bit          exp_rdy;
    logic [3:0]  exp_valid;
    logic [31:0] exp_cnt;   // {c3,c2,c1,c0}
    logic [1:0]  chk_ch;
    logic [31:0] chk_data;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0100, 1'b1, 4'b0100, 32'h0000_0000, 2'd2, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 2'd0, 32'h0,        4'b0100, 1'b1, 4'b0000, 32'h0001_0000, 2'd2, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 2'd0, 32'h000000A0, 4'b0000, 1'b1, 4'b0001, 32'h0001_0000, 2'd0, 32'h000000A0};
    tbl[3] = '{1'b1, 2'd0, 32'h000000A1, 4'b0000, 1'b0, 4'b0001, 32'h0001_0000, 2'd0, 32'h000000A0};
    tbl[4] = '{1'b1, 2'd3, 32'h000000A3, 4'b0000, 1'b1, 4'b1001, 32'h0001_0000, 2'd3, 32'h000000A3};
    tbl[5] = '{1'b1, 2'd1, 32'h000000B1, 4'b0000, 1'b1, 4'b1011, 32'h0001_0000, 2'd1, 32'h000000B1};
    tbl[6] = '{1'b1, 2'd2, 32'h000000C2, 4'b0000, 1'b1, 4'b1111, 32'h0001_0000, 2'd2, 32'h000000C2};
    tbl[7] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000, 32'h0102_0101, 2'd0, 32'h000000A0};

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Table: single route, back-pressure, bypass to other channel, concurrent drain.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d in_ready", i), {31'h0, seen_rdy}, {31'h0, tbl[i].exp_rdy});
      chk($sformatf("tbl%0d out_valid", i), {28'h0, out_valid}, {28'h0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d out_count", i), out_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d out_data", i), out_data[tbl[i].chk_ch*32 +: 32], tbl[i].chk_data);
      $display("vec %0d: v=%0b sel=%0d d=%h r=%b -> rdy=%0b valid=%b cnt=%h",
               i, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r, seen_rdy, out_valid, out_count);
    end

    // Fill every slot, then reset asynchronously between edges.
    for (int k = 0; k < 4; k++) cyc(1'b1, k[1:0], 32'h5000 + k, 4'b0000);
    chk("all full", {28'h0, out_valid}, 32'hF);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Streaming: 8 back-to-back words to ch1, then one drain cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'd1, 32'hC0DE0000 + i, 4'b0010);
      chk("stream in_ready", {31'h0, seen_rdy}, 32'h1);
      chk("stream valid1", {31'h0, out_valid[1]}, 32'h1);
      chk("stream data1", out_data[63:32], 32'hC0DE0000 + i);
      $display("stream %0d: data1=%h cnt1=%0d", i, out_data[63:32], out_count[15:8]);
    end
    cyc(1'b0, 2'd1, 32'h0, 4'b0010);
    chk("stream count1", {24'h0, out_count[15:8]}, 32'd8);

    // Counter wrap on ch0.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_clear();
    for (int i = 0; i < 256; i++) cyc(1'b1, 2'd0, i, 4'b0001);
    cyc(1'b0, 2'd0, 32'h0, 4'b0001);
    chk("wrap count0", {24'h0, out_count[7:0]}, 32'd0);
    $display("wrap: cnt0=%0d after 256 deliveries", out_count[7:0]);

    // Reset while ch1 is full and being delivered.
    cyc(1'b1, 2'd1, 32'h11112222, 4'b0000);
    in_valid = 1'b0; out_ready = 4'b0010;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst valid", {28'h0, out_valid}, 32'h0);
    chk("midrst count1", {24'h0, out_count[15:8]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc(1'b1, 2'd1, 32'h33334444, 4'b0000);
    chk("post-rst data1", out_data[63:32], 32'h33334444);
    cyc(1'b0, 2'd1, 32'h0, 4'b0010);
    chk("post-rst count1", {24'h0, out_count[15:8]}, 32'd1);
    $display("midrst: fresh word delivered, cnt1=%0d", out_count[15:8]);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 4'($urandom));
    end
    $display("random: 400 cycles done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_4_router.md
# demux1_4_router

Registered 1-to-4 demultiplexer that steers a 32-bit result word from one producer to one of four consumer channels selected by a 2-bit index. It is the distribution-side counterpart of the 32-bit 4:1 select path in the ALU datapath: where the select path gathers four sources into one, this block fans one source out to four destinations. Each destination gets a one-entry holding slot with a valid/ready handshake, so a stalled consumer blocks only transfers addressed to it. A per-channel delivered-word counter supports debug and verification.

## Interface

Parameters:
- WIDTH, 32, data width per word
- CNT_W, 8, width of each per-channel delivered-word counter

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer presents a word
- in_ready  output  1  block accepts the word this cycle
- in_sel  input  2  destination channel index, 0..3
- in_data  input  WIDTH  word to route
- out_valid  output  4  bit k: channel k slot holds a word
- out_ready  input  4  bit k: consumer k takes its word this cycle
- out_data  output  4*WIDTH  channel k data in bits [k*WIDTH +: WIDTH]
- out_count  output  4*CNT_W  channel k delivered-word count in bits [k*CNT_W +: CNT_W]

## Operation

- Input handshake: accept when in_valid && in_ready.
- in_ready is combinational: ~out_valid[in_sel] | out_ready[in_sel]. It does not depend on in_valid or on the state of unselected channels.
- On accept, slot in_sel loads in_data and sets out_valid[in_sel] = 1. Other slots are untouched.
- Output handshake k: a word is delivered when out_valid[k] && out_ready[k]. out_valid[k] clears unless a new word is accepted into slot k in the same cycle.
- Simultaneous deliver and accept on the same channel (full slot, out_ready[k] = 1, in_sel = k): the slot reloads with the new word and out_valid[k] stays 1. There is no bubble, and throughput is 1 word/cycle/channel.
- Slots on different channels drain independently in the same cycle.
- out_data[k] holds its value while out_valid[k] = 1 and out_ready[k] = 0. Its contents are don't-care when out_valid[k] = 0, but it must not change except on accept into slot k.
- out_count[k] increments by 1 on each delivery on channel k. It wraps from 2^CNT_W−1 to 0 without saturating.
- in_data and in_sel are sampled only on an accepted cycle. Values on non-accepted cycles have no effect.

## Timing

- Reset (rst = 1, asynchronous assert, synchronous-safe deassert):
  - out_valid = 4'b0000
  - out_data = 0
  - out_count = 0
  - in_ready then evaluates to 1 for every in_sel.
- Reset mid-operation discards any held words. No delivery and no count increment occur for them.
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N. It is deliverable at edge N+1 at the earliest.
- Slot state per channel: EMPTY (out_valid[k] = 0) and FULL (out_valid[k] = 1).
  - EMPTY→FULL on accept to k.
  - FULL→EMPTY on deliver without accept.
  - FULL→FULL on deliver with accept, or on hold.
- No combinational path from in_valid or in_data to any output.
- The only combinational path from out_ready to an output is the one from out_ready to in_ready.

## Structure

- Shared package (demux_pkg):
  - NUM_CH = 4
  - SEL_W = 2
  - default WIDTH and CNT_W
- Sub-module demux_slot: one-entry holding register with load/deliver logic and a CNT_W counter. It is instantiated four times in a generate loop indexed by channel.
- Top level contains only the 2-to-4 select decode (one-hot load enables) and the in_ready mux.

## Test plan

- Reset check: drive rst high with slots full → out_valid = 0, out_count all 0, in_ready = 1 immediately and asynchronously.
- Single route: in_sel = 2, in_data = 0xDEADBEEF, out_ready = 4'b0100 held high:
  - out_valid = 4'b0100 after one edge
  - out_data[2] = 0xDEADBEEF
  - delivered on the next edge
  - out_count[2] = 1
- Per-channel back-pressure: fill ch0 (out_ready[0] = 0), then present in_sel = 0 → in_ready = 0 and the word is held upstream. Present in_sel = 3 in the same state → in_ready = 1 and ch3 loads.
- Streaming: 8 back-to-back words to ch1 with out_ready[1] = 1 → in_ready stays 1, out_valid[1] stays high after the first word, data order is preserved, out_count[1] = 8.
- Concurrent drain: all four slots full, out_ready = 4'b1111, no input → all four deliver on one edge, out_valid = 0, each count +1.
- Counter wrap with CNT_W = 8: 256 deliveries on ch0 → out_count[0] returns to 0.
- Reset mid-stream: assert rst while ch1 is full and delivering → ch1 slot empties, no count increment, and the post-reset first accept behaves as a fresh start.
